// File: rtl/instr_mem_loadable.sv
// Instruction memory with a one-cycle synchronous fetch port and a byte-serial
// little-endian program-load port. Fetch is blocked while a load is running.
module instr_mem_loadable #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] A,
  output logic [31:0]       RD,
  output logic              rd_valid,
  output logic              misaligned,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned CNT_W = ADDR_W - 1;
  localparam int unsigned DEPTH = 1 << IDX_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_fetch;
  logic               w_accept;

  logic [31:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]   r_bitmap;
  logic [CNT_W-1:0]   r_ptr;
  logic [1:0]         r_byte_cnt;
  logic [31:0]        r_asm;
  logic               r_load_err;
  logic [31:0]        r_rd;
  logic               r_rd_valid;
  logic               r_misaligned;

  logic [31:0]        w_asm_next;
  logic               w_word_done;
  logic               w_full;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [IDX_W-1:0]   w_rd_idx;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-cycle fetch/accept decisions
  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_fetch = fetch_en;
        if (ld_start) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // ld_start restarts the load; any byte on that cycle is dropped
        if (!ld_start && ld_valid) begin
          w_accept = 1'b1;
          if (ld_last) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Byte assembly and write-enable generation
  always_comb begin
    w_asm_next  = r_asm | (32'(ld_data) << {r_byte_cnt, 3'b000});
    w_word_done = w_accept & ((r_byte_cnt == 2'd3) | ld_last);
    w_full      = (r_ptr == CNT_W'(DEPTH));
    w_mem_we    = w_word_done & ~w_full;
    w_wr_idx    = r_ptr[IDX_W-1:0];
    w_rd_idx    = A[ADDR_W-1:2];
  end

  // Load bookkeeping: pointer, byte lane, assembly, bitmap, overflow flag
  always_ff @(posedge clk) begin
    if (reset || ld_start) begin
      r_ptr      <= '0;
      r_byte_cnt <= 2'd0;
      r_asm      <= 32'd0;
      r_bitmap   <= '0;
      r_load_err <= 1'b0;
    end else if (w_accept) begin
      r_byte_cnt <= w_word_done ? 2'd0 : r_byte_cnt + 2'd1;
      r_asm      <= w_word_done ? 32'd0 : w_asm_next;
      if (w_word_done) begin
        if (w_full) begin
          r_load_err <= 1'b1;
        end else begin
          r_ptr              <= r_ptr + CNT_W'(1);
          r_bitmap[w_wr_idx] <= 1'b1;
        end
      end
    end
  end

  // Storage array; no reset, validity tracked by the bitmap
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wr_idx] <= w_asm_next;
    end
  end

  // Registered fetch port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd         <= 32'd0;
      r_rd_valid   <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (w_fetch) begin
      r_rd_valid <= 1'b1;
      if (A[1:0] != 2'b00) begin
        r_rd         <= 32'd0;
        r_misaligned <= 1'b1;
      end else begin
        r_rd         <= r_bitmap[w_rd_idx] ? r_mem[w_rd_idx] : 32'd0;
        r_misaligned <= 1'b0;
      end
    end else begin
      r_rd_valid   <= 1'b0;
      r_misaligned <= 1'b0;
    end
  end

  assign RD           = r_rd;
  assign rd_valid     = r_rd_valid;
  assign misaligned   = r_misaligned;
  assign ld_ready     = (r_state == ST_LOAD);
  assign load_busy    = (r_state == ST_LOAD);
  assign load_err     = r_load_err;
  assign words_loaded = r_ptr;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: an ADDR_W=8 instance and an ADDR_W=4
// instance, each driven from one linear sequence with a reference model and
// a queue of expected fetch results.
module tb_instr_mem_loadable;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADDR_W = 8 instance
  logic        rst8, fe8, st8, lv8, ll8;
  logic [7:0]  a8, ld8;
  logic [31:0] rd8;
  logic        rv8, mis8, rdy8, busy8, err8;
  logic [6:0]  wl8;

  // ADDR_W = 4 instance
  logic        rst4, fe4, st4, lv4, ll4;
  logic [3:0]  a4;
  logic [7:0]  ld4;
  logic [31:0] rd4;
  logic        rv4, mis4, rdy4, busy4, err4;
  logic [2:0]  wl4;

  instr_mem_loadable #(.ADDR_W(8)) u_dut8 (
    .clk(clk), .reset(rst8), .fetch_en(fe8), .A(a8), .RD(rd8),
    .rd_valid(rv8), .misaligned(mis8), .ld_start(st8), .ld_valid(lv8),
    .ld_data(ld8), .ld_last(ll8), .ld_ready(rdy8), .load_busy(busy8),
    .load_err(err8), .words_loaded(wl8)
  );

  instr_mem_loadable #(.ADDR_W(4)) u_dut4 (
    .clk(clk), .reset(rst4), .fetch_en(fe4), .A(a4), .RD(rd4),
    .rd_valid(rv4), .misaligned(mis4), .ld_start(st4), .ld_valid(lv4),
    .ld_data(ld4), .ld_last(ll4), .ld_ready(rdy4), .load_busy(busy4),
    .load_err(err4), .words_loaded(wl4)
  );

  typedef struct {
    logic [31:0] rd;
    logic        valid;
    logic        mis;
  } fetch_exp_t;

  fetch_exp_t  exp_q[$];
  logic [7:0]  lq[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = ADDR_W 8, index 1 = ADDR_W 4
  logic [31:0] m_mem  [2][64];
  bit          m_wr   [2][64];
  int          m_ptr  [2];
  int          m_bcnt [2];
  logic [31:0] m_acc  [2];
  logic [31:0] m_rd   [2];
  bit          m_err  [2];
  bit          m_busy [2];

  function automatic int depth(input int s);
    return (s != 0) ? 4 : 64;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int s);
    for (int i = 0; i < 64; i++) m_wr[s][i] = 1'b0;
    m_ptr[s]  = 0;
    m_bcnt[s] = 0;
    m_acc[s]  = 32'd0;
    m_err[s]  = 1'b0;
  endtask

  // Compare every status output of one instance with the model
  task automatic chk_status(input int s, input string tag);
    if (s != 0) begin
      chk({tag, "_ready"}, 32'(rdy4), 32'(m_busy[s]));
      chk({tag, "_busy"},  32'(busy4), 32'(m_busy[s]));
      chk({tag, "_err"},   32'(err4), 32'(m_err[s]));
      chk({tag, "_wl"},    32'(wl4), 32'(m_ptr[s]));
    end else begin
      chk({tag, "_ready"}, 32'(rdy8), 32'(m_busy[s]));
      chk({tag, "_busy"},  32'(busy8), 32'(m_busy[s]));
      chk({tag, "_err"},   32'(err8), 32'(m_err[s]));
      chk({tag, "_wl"},    32'(wl8), 32'(m_ptr[s]));
    end
  endtask

  task automatic start(input int s);
    if (s != 0) st4 = 1'b1; else st8 = 1'b1;
    step();
    if (s != 0) st4 = 1'b0; else st8 = 1'b0;
    model_clear(s);
    m_busy[s] = 1'b1;
  endtask

  task automatic send(input int s, input logic [7:0] d, input logic last);
    if (s != 0) begin lv4 = 1'b1; ld4 = d; ll4 = last; end
    else        begin lv8 = 1'b1; ld8 = d; ll8 = last; end
    m_acc[s] = m_acc[s] | (32'(d) << (8 * m_bcnt[s]));
    if (m_bcnt[s] == 3 || last) begin
      if (m_ptr[s] < depth(s)) begin
        m_mem[s][m_ptr[s]] = m_acc[s];
        m_wr[s][m_ptr[s]]  = 1'b1;
        m_ptr[s]++;
      end else begin
        m_err[s] = 1'b1;
      end
      m_acc[s]  = 32'd0;
      m_bcnt[s] = 0;
    end else begin
      m_bcnt[s]++;
    end
    if (last) m_busy[s] = 1'b0;
    step();
    if (s != 0) begin lv4 = 1'b0; ll4 = 1'b0; end
    else        begin lv8 = 1'b0; ll8 = 1'b0; end
  endtask

  // Full load of the bytes in lq, last byte flagged with ld_last
  task automatic load(input int s, input string tag);
    start(s);
    chk_status(s, {tag, "_start"});
    for (int i = 0; i < lq.size(); i++) send(s, lq[i], (i == lq.size() - 1));
    chk_status(s, {tag, "_end"});
  endtask

  task automatic push_words(input logic [31:0] w);
    for (int k = 0; k < 4; k++) lq.push_back(8'(w >> (8 * k)));
  endtask

  // One-cycle fetch: expectation queued at drive, popped after the edge
  task automatic fetch(input int s, input logic [7:0] addr, input string tag);
    fetch_exp_t e;
    int idx;
    if (m_busy[s]) begin
      e.rd = m_rd[s]; e.valid = 1'b0; e.mis = 1'b0;
    end else if (addr[1:0] != 2'b00) begin
      e.rd = 32'd0; e.valid = 1'b1; e.mis = 1'b1;
    end else begin
      idx = int'(addr[7:2]) % depth(s);
      e.rd = m_wr[s][idx] ? m_mem[s][idx] : 32'd0;
      e.valid = 1'b1; e.mis = 1'b0;
    end
    m_rd[s] = e.rd;
    exp_q.push_back(e);
    if (s != 0) begin fe4 = 1'b1; a4 = addr[3:0]; end
    else        begin fe8 = 1'b1; a8 = addr; end
    step();
    if (s != 0) fe4 = 1'b0; else fe8 = 1'b0;
    e = exp_q.pop_front();
    if (s != 0) begin
      chk({tag, "_rd"}, rd4, e.rd);
      chk({tag, "_valid"}, 32'(rv4), 32'(e.valid));
      chk({tag, "_mis"}, 32'(mis4), 32'(e.mis));
    end else begin
      chk({tag, "_rd"}, rd8, e.rd);
      chk({tag, "_valid"}, 32'(rv8), 32'(e.valid));
      chk({tag, "_mis"}, 32'(mis8), 32'(e.mis));
    end
  endtask

  initial begin
    rst8 = 1'b1; fe8 = 1'b0; st8 = 1'b0; lv8 = 1'b0; ll8 = 1'b0; a8 = '0; ld8 = '0;
    rst4 = 1'b1; fe4 = 1'b0; st4 = 1'b0; lv4 = 1'b0; ll4 = 1'b0; a4 = '0; ld4 = '0;
    for (int s = 0; s < 2; s++) begin
      model_clear(s);
      m_rd[s] = 32'd0;
      m_busy[s] = 1'b0;
    end
    step();
    step();
    rst8 = 1'b0;
    rst4 = 1'b0;

    // Reset values
    chk("rst8_rd", rd8, 32'd0);
    chk("rst8_valid", 32'(rv8), 32'd0);
    chk("rst8_mis", 32'(mis8), 32'd0);
    chk_status(0, "rst8");
    chk("rst4_rd", rd4, 32'd0);
    chk_status(1, "rst4");

    // Fetch from empty memory
    fetch(0, 8'h00, "empty0");

    // Six-word program
    lq.delete();
    push_words(32'h00700213); push_words(32'h00200093); push_words(32'h0010e113);
    push_words(32'h00127193); push_words(32'h00108093); push_words(32'hfe409ee3);
    load(0, "prog6");
    fetch(0, 8'h14, "f14");
    fetch(0, 8'h18, "f18");
    fetch(0, 8'h00, "f00");
    fetch(0, 8'h06, "f06mis");
    fetch(0, 8'h08, "f08");

    // Fetch blocked during load; restart mid-word; partial final word
    start(0);
    chk_status(0, "ld2_start");
    fetch(0, 8'h14, "fetch_in_load");
    send(0, 8'h55, 1'b0);
    send(0, 8'h66, 1'b0);
    send(0, 8'h77, 1'b0);
    start(0);
    chk_status(0, "restart");
    send(0, 8'h13, 1'b0);
    send(0, 8'h02, 1'b1);
    chk_status(0, "partial_end");
    fetch(0, 8'h00, "partial_w0");
    fetch(0, 8'h04, "partial_w1");

    // Reset in the middle of a load
    start(0);
    for (int i = 0; i < 6; i++) send(0, 8'(8'hA0 + i), 1'b0);
    chk_status(0, "midload");
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
    model_clear(0);
    m_busy[0] = 1'b0;
    m_rd[0] = 32'd0;
    chk_status(0, "midrst");
    chk("midrst_rd", rd8, 32'd0);
    fetch(0, 8'h00, "midrst_f00");

    // Overflow on the four-word instance
    lq.delete();
    push_words(32'hA3A2A1A0); push_words(32'hB3B2B1B0); push_words(32'hC3C2C1C0);
    push_words(32'hD3D2D1D0); push_words(32'hE3E2E1E0);
    load(1, "ovf");
    fetch(1, 8'h00, "ovf_w0");
    fetch(1, 8'h0C, "ovf_w3");
    start(1);
    chk_status(1, "ovf_clear");
    send(1, 8'hAB, 1'b1);
    chk_status(1, "small_end");
    fetch(1, 8'h00, "small_w0");
    fetch(1, 8'h04, "small_w1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
